// File: rtl/rx_pkg.sv
// ============================================================================
// Module      : rx_pkg
// Description : Shared types, defaults and line-state helpers for the USB
//               full-speed receive bit-timing path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    EOP_WAIT = 2'd2
  } rx_state_t;

  localparam int RX_CLKS_PER_BIT_DEFAULT = 8;
  localparam int RX_SAMPLE_PHASE_DEFAULT = 3;

  // Differential line states: J = idle (D+ high), K = D- high, SE0 = both low.
  function automatic logic line_is_j(input logic dp, input logic dm);
    return dp & ~dm;
  endfunction

  function automatic logic line_is_k(input logic dp, input logic dm);
    return ~dp & dm;
  endfunction

  function automatic logic line_is_se0(input logic dp, input logic dm);
    return ~dp & ~dm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_edge_detect.sv
// ============================================================================
// Module      : rx_edge_detect
// Description : Registers the previous D+ level and flags any D+ transition
//               and D+ falling transitions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_edge_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  output logic d_plus_edge,
  output logic falling_edge
);

  logic r_d_plus_prev;

  // Resets to the idle J level so an idle line never looks like an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_d_plus_prev <= 1'b1;
    end else begin
      r_d_plus_prev <= d_plus_sync;
    end
  end

  assign d_plus_edge  = d_plus_sync ^ r_d_plus_prev;
  assign falling_edge = r_d_plus_prev & ~d_plus_sync;

endmodule

`default_nettype wire

// File: rtl/rx_bit_ctrl.sv
// ============================================================================
// Module      : rx_bit_ctrl
// Description : USB full-speed RX bit-timing controller: start-of-packet
//               detection, mid-bit sampling, NRZI decode, byte and EOP flags.
//               Build option RX_RESYNC_EN: every D+ edge re-centres the phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_bit_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEFAULT,
  parameter int SAMPLE_PHASE = RX_SAMPLE_PHASE_DEFAULT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  output logic shift_enable,
  output logic rx_bit,
  output logic byte_received,
  output logic eop,
  output logic rx_error,
  output logic packet_active
);

  localparam int PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PHASE_W-1:0] c_phase_last   = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] c_sample_phase = PHASE_W'(SAMPLE_PHASE);

  rx_state_t          r_state;
  rx_state_t          w_state_next;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_next;
  logic [2:0]         r_bit_cnt;
  logic               r_last_sample;
  logic               r_rx_error;
  logic               r_byte_received;

  logic w_d_plus_edge;
  logic w_falling_edge;
  logic w_resync;
  logic w_sample_point;
  logic w_se0;
  logic w_line_j;
  logic w_sop;
  logic w_shift;
  logic w_eop;

  rx_edge_detect u_edge_detect (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_sync  (d_plus_sync),
    .d_plus_edge  (w_d_plus_edge),
    .falling_edge (w_falling_edge)
  );

`ifdef RX_RESYNC_EN
  assign w_resync = w_d_plus_edge;
`else
  logic w_unused_edge;
  assign w_unused_edge = w_d_plus_edge;
  assign w_resync      = 1'b0;
`endif

  assign w_sample_point = (r_phase == c_sample_phase);
  assign w_se0          = line_is_se0(d_plus_sync, d_minus_sync);
  assign w_line_j       = line_is_j(d_plus_sync, d_minus_sync);

  always_comb begin
    if (w_resync) begin
      w_phase_next = '0;
    end else if (r_phase == c_phase_last) begin
      w_phase_next = '0;
    end else begin
      w_phase_next = r_phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Start of packet needs a true J->K transition; a J->SE0 glitch also drops
  // D+ but must not open a packet.
  always_comb begin
    w_state_next = r_state;
    w_sop        = 1'b0;
    w_shift      = 1'b0;
    w_eop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_falling_edge && line_is_k(d_plus_sync, d_minus_sync)) begin
          w_sop        = 1'b1;
          w_state_next = RECEIVE;
        end
      end
      RECEIVE: begin
        if (w_sample_point) begin
          if (w_se0) begin
            w_eop        = 1'b1;
            w_state_next = EOP_WAIT;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      EOP_WAIT: begin
        if (w_sample_point && w_line_j) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_phase         <= '0;
      r_bit_cnt       <= 3'd0;
      r_last_sample   <= 1'b1;
      r_rx_error      <= 1'b0;
      r_byte_received <= 1'b0;
    end else begin
      r_byte_received <= w_shift && (r_bit_cnt == 3'd7);
      if (w_sop) begin
        r_phase       <= '0;
        r_bit_cnt     <= 3'd0;
        r_last_sample <= 1'b1;
        r_rx_error    <= 1'b0;
      end else if (r_state != IDLE) begin
        r_phase <= w_phase_next;
        if (w_shift) begin
          r_last_sample <= d_plus_sync;
          r_bit_cnt     <= r_bit_cnt + 3'd1;
        end
        if (w_eop) begin
          r_rx_error <= (r_bit_cnt != 3'd0);
        end
      end
    end
  end

  // NRZI: no transition since the previous sample decodes as a one.
  assign shift_enable  = w_shift;
  assign rx_bit        = w_shift & (d_plus_sync == r_last_sample);
  assign eop           = w_eop;
  assign byte_received = r_byte_received;
  assign rx_error      = r_rx_error;
  assign packet_active = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_bit_ctrl.sv
// ============================================================================
// Module      : tb_rx_bit_ctrl
// Description : Self-checking bench for rx_bit_ctrl (vector table, directed
//               packets, randomized line traffic against a timing model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_bit_ctrl;

  localparam int CPB   = 8;
  localparam int SP    = 3;
  localparam int TBL_N = 106;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic d_plus_sync = 1'b1;
  logic d_minus_sync = 1'b0;
  logic shift_enable, rx_bit, byte_received, eop, rx_error, packet_active;

  rx_bit_ctrl #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .d_plus_sync   (d_plus_sync),
    .d_minus_sync  (d_minus_sync),
    .shift_enable  (shift_enable),
    .rx_bit        (rx_bit),
    .byte_received (byte_received),
    .eop           (eop),
    .rx_error      (rx_error),
    .packet_active (packet_active)
  );

  always #5 clk = ~clk;

  // Output vector layout: {shift_enable, rx_bit, byte_received, eop, rx_error, packet_active}
  typedef struct {
    logic       dp;
    logic       dm;
    logic [5:0] want;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  vec_t       vt [TBL_N];
  logic       wave_dp [$];
  logic       wave_dm [$];
  logic [5:0] exp_q [$];
  logic [5:0] obs_q [$];

  function automatic logic [5:0] outs();
    return {shift_enable, rx_bit, byte_received, eop, rx_error, packet_active};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic wave_clear();
    wave_dp.delete();
    wave_dm.delete();
  endtask

  task automatic push_line(input logic dp, input logic dm, input int n);
    for (int i = 0; i < n; i++) begin
      wave_dp.push_back(dp);
      wave_dm.push_back(dm);
    end
  endtask

  // Reference: walks the waveform packet by packet using absolute sample times
  // (start edge + 1 + SP, then every CPB cycles) and counts bits arithmetically.
  task automatic build_model();
    int   mode, next_s, nbits, byte_at;
    logic last, err, err_next, prev, dp, dm, shift, bitv, eopv, was_active;
    mode = 0; next_s = -1; nbits = 0; byte_at = -1;
    last = 1'b1; err = 1'b0;
    exp_q.delete();
    for (int c = 0; c < wave_dp.size(); c++) begin
      dp   = wave_dp[c];
      dm   = wave_dm[c];
      prev = (c == 0) ? 1'b1 : wave_dp[c-1];
      shift = 1'b0; bitv = 1'b0; eopv = 1'b0;
      err_next   = err;
      was_active = (mode != 0);
      if (mode == 0) begin
        if (prev && !dp && dm) begin
          mode = 1; next_s = c + 1 + SP; last = 1'b1; nbits = 0; err_next = 1'b0;
        end
      end else if (c == next_s) begin
        next_s = c + CPB;
        if (mode == 1) begin
          if (!dp && !dm) begin
            eopv = 1'b1; err_next = ((nbits % 8) != 0); mode = 2;
          end else begin
            shift = 1'b1; bitv = (dp == last); last = dp; nbits++;
            if ((nbits % 8) == 0) byte_at = c + 1;
          end
        end else if (dp && !dm) begin
          mode = 0;
        end
      end
`ifdef RX_RESYNC_EN
      if (was_active && mode != 0 && dp != prev) next_s = c + 1 + SP;
`endif
      exp_q.push_back({shift, bitv, logic'(c == byte_at), eopv, err, was_active});
      err = err_next;
    end
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk); #1;
    d_plus_sync = 1'b1; d_minus_sync = 1'b0;
    n_rst = 1'b0;
    #1;
    check({name, " reset outputs"}, 32'(outs()), 32'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  // Plays wave cycles 0..n-1; cycle 0 starts at the current posedge+1.
  task automatic run_wave(input string name, input bit do_reset, input int n_play);
    int n;
    logic [5:0] got;
    n = (n_play < 0 || n_play > wave_dp.size()) ? wave_dp.size() : n_play;
    build_model();
    obs_q.delete();
    if (do_reset) apply_reset(name);
    for (int c = 0; c < n; c++) begin
      d_plus_sync  = wave_dp[c];
      d_minus_sync = wave_dm[c];
      @(negedge clk);
      got = outs();
      obs_q.push_back(got);
      check($sformatf("%s cycle %0d", name, c), 32'(got), 32'(exp_q[c]));
      @(posedge clk); #1;
    end
  endtask

  function automatic int count_bytes();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i][3]) n++;
    return n;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sync_lv;
    logic       lv;
    int         t0, eop_c, j_c, sop_c, late, len, nb;

    // ---- vector table: SE0 glitch in idle, SYNC byte, SE0, J ----
    sync_lv = 8'b0010_1010;
    for (int i = 0; i < TBL_N; i++) begin
      vt[i].dp = 1'b1; vt[i].dm = 1'b0; vt[i].want = 6'd0;
    end
    vt[2].dp = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < CPB; k++) begin
        vt[6 + b*CPB + k].dp = sync_lv[b];
        vt[6 + b*CPB + k].dm = ~sync_lv[b];
      end
    for (int i = 70; i < 86; i++) begin
      vt[i].dp = 1'b0; vt[i].dm = 1'b0;
    end
    for (int i = 7; i <= 90; i++) vt[i].want[0] = 1'b1;
    for (int k = 0; k < 8; k++) vt[10 + 8*k].want[5] = 1'b1;
    vt[66].want[4] = 1'b1;
    vt[67].want[3] = 1'b1;
    vt[74].want[2] = 1'b1;

    apply_reset("table");
    for (int c = 0; c < TBL_N; c++) begin
      d_plus_sync  = vt[c].dp;
      d_minus_sync = vt[c].dm;
      @(negedge clk);
      check($sformatf("table cycle %0d", c), 32'(outs()), 32'(vt[c].want));
      @(posedge clk); #1;
    end

    // ---- 16 data bits, SE0 two bit times, J ----
    t0 = 2;
    wave_clear();
    push_line(1'b1, 1'b0, t0);
    lv = 1'b0;
    for (int b = 0; b < 16; b++) begin
      if (b > 0 && $urandom_range(0, 1) == 1) lv = ~lv;
      push_line(lv, ~lv, CPB);
    end
    push_line(1'b0, 1'b0, 2*CPB);
    push_line(1'b1, 1'b0, 3*CPB);
    run_wave("16bit", 1'b1, -1);
    eop_c = t0 + 1 + SP + 16*CPB;
    j_c   = eop_c + 2*CPB;
    check("16bit byte pulses", 32'(count_bytes()), 32'd2);
    check("16bit eop", 32'(obs_q[eop_c][2]), 32'd1);
    check("16bit rx_error", 32'(obs_q[eop_c+1][1]), 32'd0);
    check("16bit active at J sample", 32'(obs_q[j_c][0]), 32'd1);
    check("16bit active after J sample", 32'(obs_q[j_c+1][0]), 32'd0);

    // ---- 12 bits then SE0: rx_error, cleared by next J->K ----
    wave_clear();
    push_line(1'b1, 1'b0, t0);
    lv = 1'b0;
    for (int b = 0; b < 12; b++) begin
      if (b > 0 && (b % 3) != 0) lv = ~lv;
      push_line(lv, ~lv, CPB);
    end
    push_line(1'b0, 1'b0, 2*CPB);
    push_line(1'b1, 1'b0, 20);
    push_line(1'b0, 1'b1, 10);
    run_wave("12bit", 1'b1, -1);
    eop_c = t0 + 1 + SP + 12*CPB;
    sop_c = t0 + 12*CPB + 2*CPB + 20;
    check("12bit eop", 32'(obs_q[eop_c][2]), 32'd1);
    check("12bit rx_error set", 32'(obs_q[eop_c+1][1]), 32'd1);
    check("12bit rx_error held to sop", 32'(obs_q[sop_c][1]), 32'd1);
    check("12bit rx_error cleared", 32'(obs_q[sop_c+1][1]), 32'd0);

    // ---- late edge: bit 2 stretched by 2 cycles ----
    wave_clear();
    push_line(1'b1, 1'b0, t0);
    lv = 1'b1;
    for (int b = 0; b < 6; b++) begin
      lv = ~lv;
      push_line(lv, ~lv, (b == 2) ? CPB + 2 : CPB);
    end
    push_line(1'b0, 1'b0, 2*CPB);
    push_line(1'b1, 1'b0, 3*CPB);
    run_wave("late edge", 1'b1, -1);
`ifdef RX_RESYNC_EN
    late = 2;
`else
    late = 0;
`endif
    check("late edge nominal slot", 32'(obs_q[t0 + 1 + SP + 3*CPB][5]), 32'(late == 0));
    check("late edge shifted slot", 32'(obs_q[t0 + 1 + SP + 3*CPB + 2][5]), 32'(late == 2));

    // ---- reset asserted in the sixth sample cycle ----
    wave_clear();
    push_line(1'b1, 1'b0, t0);
    for (int b = 0; b < 8; b++) push_line(sync_lv[b], ~sync_lv[b], CPB);
    push_line(1'b1, 1'b0, 10);
    run_wave("pre-reset", 1'b1, t0 + 1 + SP + 5*CPB);
    check("pre-reset strobes", 32'($countones({obs_q[6][5], obs_q[14][5], obs_q[22][5],
                                                  obs_q[30][5], obs_q[38][5]})), 32'd5);
    d_plus_sync  = wave_dp[t0 + 1 + SP + 5*CPB];
    d_minus_sync = wave_dm[t0 + 1 + SP + 5*CPB];
    n_rst = 1'b0;
    #1;
    check("mid-byte reset outputs", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    d_plus_sync = 1'b1; d_minus_sync = 1'b0;
    #1;
    check("held reset outputs", 32'(outs()), 32'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    wave_clear();
    push_line(1'b1, 1'b0, 3);
    for (int b = 0; b < 8; b++) push_line(sync_lv[b], ~sync_lv[b], CPB);
    push_line(1'b0, 1'b0, 2*CPB);
    push_line(1'b1, 1'b0, 3*CPB);
    run_wave("post-reset", 1'b0, -1);
    check("post-reset byte pulse", 32'(obs_q[3 + 1 + SP + 7*CPB + 1][3]), 32'd1);
    check("post-reset byte count", 32'(count_bytes()), 32'd1);

    // ---- randomized traffic with idle glitches and bit-length jitter ----
    for (int it = 0; it < 4; it++) begin
      wave_clear();
      push_line(1'b1, 1'b0, 3);
      for (int p = 0; p < 5; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          push_line(1'b0, 1'b0, int'($urandom_range(1, 2)));
          push_line(1'b1, 1'b0, int'($urandom_range(2, 6)));
        end
        push_line(1'b1, 1'b0, int'($urandom_range(1, 10)));
        nb = int'($urandom_range(1, 30));
        lv = 1'b0;
        for (int b = 0; b < nb; b++) begin
          if (b > 0 && $urandom_range(0, 1) == 1) lv = ~lv;
          len = CPB;
          if (it >= 2) len = CPB + int'($urandom_range(0, 2)) - 1;
          push_line(lv, ~lv, len);
        end
        push_line(1'b0, 1'b0, 2*CPB);
        push_line(1'b1, 1'b0, 2*CPB + int'($urandom_range(0, 10)));
      end
      run_wave($sformatf("random %0d", it), 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_bit_ctrl.md
# rx_bit_ctrl

Bit-timing controller for the USB full-speed receive path. It takes the synchronized D+/D− lines, detects start of packet, and keeps a phase counter that schedules one mid-bit sample per bit period. At each sample it emits a shift strobe with the NRZI-decoded bit, flags byte boundaries, and detects EOP (SE0). It sits between the RX input synchronizers and the RX shift register / packet decoder. Bit-unstuffing is not part of this block.

## Interface
- CLKS_PER_BIT, 8: clock cycles per USB bit period; minimum 4.
- SAMPLE_PHASE, 3: phase count at which a bit is sampled; must be < CLKS_PER_BIT.
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- d_plus_sync  input  1  synchronized D+ (idle J = 1).
- d_minus_sync  input  1  synchronized D− (idle J = 0).
- shift_enable  output  1  one-cycle strobe; rx_bit is valid.
- rx_bit  output  1  NRZI-decoded bit: 1 = no transition since the previous sample.
- byte_received  output  1  one-cycle pulse after every 8th shift_enable.
- eop  output  1  one-cycle pulse when SE0 is sampled.
- rx_error  output  1  set with eop if the bit count is not a multiple of 8; cleared on next start of packet.
- packet_active  output  1  high from start of packet until return to IDLE.

## Operation
- Registers:
  - d_plus_prev (reset 1)
  - last_sample (reset 1)
  - phase counter 0..CLKS_PER_BIT−1 (reset 0)
  - bit_cnt 0..7 (reset 0)
  - state (reset IDLE)
- edge = d_plus_sync != d_plus_prev.
- States:
  - IDLE: wait for a falling edge on D+ (J→K). On edge: phase←0, bit_cnt←0, last_sample←1, rx_error←0; go to RECEIVE.
  - RECEIVE:
    - Phase counts each cycle and wraps at CLKS_PER_BIT−1.
    - At phase == SAMPLE_PHASE with D+/D− not both 0: shift_enable=1, rx_bit=(d_plus_sync==last_sample), last_sample←d_plus_sync, bit_cnt increments mod 8.
    - When the increment wraps 7→0, byte_received pulses on the next cycle.
    - At phase == SAMPLE_PHASE with SE0: no shift_enable. eop=1 for that cycle, rx_error←(bit_cnt!=0). Go to EOP_WAIT.
  - EOP_WAIT: phase keeps counting. At phase == SAMPLE_PHASE with d_plus_sync==1 and d_minus_sync==0 (J), go to IDLE. Otherwise stay.
- Outputs:
  - shift_enable, rx_bit and eop are decodes of registered state/phase plus the synchronized inputs. No further synchronization is done here.
  - packet_active = (state != IDLE).
- Reset at any time, including mid-packet: immediate return to IDLE. All outputs 0, except that rx_bit reads 0 and last_sample/d_plus_prev read 1.

## Timing
- The edge cycle t is the cycle in which d_plus_sync first differs from d_plus_prev.
- Phase = 0 at t+1; the first shift_enable is at t+1+SAMPLE_PHASE (t+4 with defaults).
- Subsequent samples follow every CLKS_PER_BIT cycles.
- byte_received is high exactly one cycle after the 8th shift_enable of each byte. It can coincide with the next byte's phase progression but never with a shift_enable (requires CLKS_PER_BIT ≥ 2).
- eop is high in the sample cycle; packet_active drops one cycle after the J sample in EOP_WAIT.
- SE0 and an edge in the same sample cycle: SE0 handling wins.
- Back-to-back packets: a J→K edge in the cycle after returning to IDLE is accepted.

## Configuration
- RX_RESYNC_EN defined: in RECEIVE and EOP_WAIT, every D+ edge reloads phase←0 on the next cycle, so each transition re-centres the sample point. An edge in the same cycle as a sample still produces that sample.
- Not defined: the phase counter free-runs from the start-of-packet edge; later edges are ignored for timing.

## Structure
- Shared package rx_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, RECEIVE, EOP_WAIT})
  - the default localparams for CLKS_PER_BIT and SAMPLE_PHASE.
- One natural sub-module, rx_edge_detect: holds d_plus_prev (reset 1) and outputs edge and falling_edge.
- The counters and FSM live in rx_bit_ctrl.

## Test plan
- SYNC byte KJKJKJKK with defaults:
  - first shift_enable at t+4, then every 8 cycles.
  - rx_bit sequence 0,0,0,0,0,0,0,1.
  - byte_received pulses one cycle after the 8th strobe.
- 16 data bits, then SE0 for 2 bit times, then J:
  - two byte_received pulses.
  - eop at the first SE0 sample with rx_error=0.
  - packet_active low after the J sample.
- 12 bits, then SE0: eop=1 and rx_error=1; rx_error clears at the next J→K edge.
- With RX_RESYNC_EN, inject an edge 2 cycles late relative to the nominal bit boundary:
  - the next shift_enable shifts 2 cycles later.
  - without the macro it stays on the original grid.
- Assert n_rst mid-byte, after 5 strobes:
  - all outputs 0 immediately, state IDLE.
  - after release, a new J→K edge starts a fresh byte with bit_cnt=0.
- Idle line with SE0 glitch in IDLE: no packet_active and no eop.
